// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS multiply/divide unit
package mips_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum         = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    // Remainder is below the divisor, so after the shift it needs one extra bit.
    rem_shifted = acc[2*WIDTH-1:WIDTH-1];
    diff        = rem_shifted - {1'b0, operand};
    if (!is_div) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {rem_shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH      = MULDIV_WIDTH,
  parameter int ITERATIONS = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in_0,
  input  logic [WIDTH-1:0] data_in_1,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITERATIONS + 1);

  muldiv_state_t      state, state_next;
  muldiv_op_t         op_q;
  logic [WIDTH-1:0]   a_q, b_q, mag_a, mag_b, operand;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [CW-1:0]      count;
  logic               sign_a, sign_b, dz_q;
  logic               is_div, signed_op, divisor_zero;

  assign is_div       = op_q[1];
  assign signed_op    = op_q[0];
  assign divisor_zero = (b_q == '0);
  assign mag_a        = (signed_op && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b        = (signed_op && b_q[WIDTH-1]) ? -b_q : b_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state)
      IDLE: if (start) state_next = PREP;
      PREP: begin
        busy       = 1'b1;
        state_next = (is_div && divisor_zero) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (count == CW'(ITERATIONS - 1)) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done        = 1'b1;
        div_by_zero = dz_q;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      op_q    <= MULTU;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      operand <= '0;
      count   <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_q <= muldiv_op_t'(op);
            a_q  <= data_in_0;
            b_q  <= data_in_1;
            dz_q <= 1'b0;
          end
        end
        PREP: begin
          sign_a <= signed_op & a_q[WIDTH-1];
          sign_b <= signed_op & b_q[WIDTH-1];
          count  <= '0;
          if (is_div) begin
            acc     <= {{WIDTH{1'b0}}, mag_a};
            operand <= mag_b;
            if (divisor_zero) begin
              hi   <= a_q;
              lo   <= '1;
              dz_q <= 1'b1;
            end
          end else begin
            acc     <= {{WIDTH{1'b0}}, mag_b};
            operand <= mag_a;
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + CW'(1);
        end
        FIX: begin
          // Quotient sign follows the operand signs; remainder follows the dividend.
          if (is_div) begin
            lo <= (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi <= sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end else begin
            {hi, lo} <= (sign_a ^ sign_b) ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] data_in_0, data_in_1, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .data_in_0   (data_in_0),
    .data_in_1   (data_in_1),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    edz = 1'b0;
    eh  = '0;
    el  = '0;
    if (o == 2'd0) begin
      p = {32'b0, a} * {32'b0, b};
      eh = p[63:32]; el = p[31:0];
    end else if (o == 2'd1) begin
      p = sa * sb;
      eh = p[63:32]; el = p[31:0];
    end else if (b == 32'd0) begin
      eh = a; el = 32'hFFFF_FFFF; edz = 1'b1;
    end else if (o == 2'd2) begin
      el = a / b; eh = a % b;
    end else begin
      q = sa / sb; r = sa % sb;
      el = q[31:0]; eh = r[31:0];
    end
  endfunction

  // Launch one op, wait for done (bounded), capture results, return in the following IDLE cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] rh, output logic [31:0] rl,
                        output logic rdz, output int busy_bad);
    op = o; data_in_0 = a; data_in_1 = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_bad = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_bad++;
      tick();
      lat++;
    end
    if (busy) busy_bad++;
    rh = hi; rl = lo; rdz = div_by_zero;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got busy=%b done=%b dz=%b expected 0 0 0", busy, done, div_by_zero);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_hilo: got hi=%h lo=%h expected 0 0", hi, lo);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [1:0]  ops [5] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3};
    logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] ehs [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd0};
    logic [31:0] els [5] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    int          lats[5] = '{35, 35, 35, 2, 35};
    int lat, bb;
    logic [31:0] rh, rl;
    logic rdz;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], lat, rh, rl, rdz, bb);
      checks++;
      if (lat !== lats[i]) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, lats[i]); end
      checks++;
      if (bb !== 0) begin errors++; $display("FAIL dir_busy[%0d]: got %0d bad busy cycles expected 0", i, bb); end
      checks++;
      if (rh !== ehs[i] || rl !== els[i]) begin
        errors++; $display("FAIL dir_result[%0d]: got hi=%h lo=%h expected hi=%h lo=%h", i, rh, rl, ehs[i], els[i]);
      end
      checks++;
      if (rdz !== (lats[i] == 2)) begin errors++; $display("FAIL dir_dz[%0d]: got %b expected %b", i, rdz, lats[i] == 2); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, eh, el, rh, rl;
    logic edz, rdz;
    int lat, bb;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = $urandom_range(0, 9);
      if (i % 6 == 2) b = 32'd0;
      if (i % 5 == 3) a = $urandom_range(0, 200);
      model(o, a, b, eh, el, edz);
      run_op(o, a, b, lat, rh, rl, rdz, bb);
      checks++;
      if (rh !== eh || rl !== el || rdz !== edz || lat !== (edz ? 2 : 35) || bb !== 0) begin
        errors++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h dz=%b lat=%0d busybad=%0d expected hi=%h lo=%h dz=%b lat=%0d",
                 i, o, a, b, rh, rl, rdz, lat, bb, eh, el, edz, edz ? 2 : 35);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] lo_before, eh, el;
    logic edz;
    int done_count;
    wdata = 32'h1234; hi_we = 1'b1;
    lo_before = lo;
    tick();
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'h1234 || lo !== lo_before) begin
      errors++; $display("FAIL mthi_idle: got hi=%h lo=%h expected hi=00001234 lo=%h", hi, lo, lo_before);
    end
    op = 2'd0; data_in_0 = 32'd12345; data_in_1 = 32'd678; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    lo_before = lo;
    lo_we = 1'b1; wdata = 32'h55;
    tick();
    lo_we = 1'b0;
    checks++;
    if (lo !== lo_before) begin errors++; $display("FAIL mtlo_busy: got lo=%h expected %h", lo, lo_before); end
    data_in_0 = 32'd7; data_in_1 = 32'd9; op = 2'd2; start = 1'b1;
    tick(); start = 1'b0;
    done_count = 0;
    for (int c = 0; c < 60; c++) begin
      if (done) done_count++;
      tick();
    end
    model(2'd0, 32'd12345, 32'd678, eh, el, edz);
    checks++;
    if (done_count !== 1) begin errors++; $display("FAIL start_ignored_done_count: got %0d expected 1", done_count); end
    checks++;
    if (hi !== eh || lo !== el) begin
      errors++; $display("FAIL start_ignored_result: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, eh, el);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bb, done_count;
    logic [31:0] rh, rl;
    logic rdz;
    op = 2'd0; data_in_0 = 32'hDEAD_BEEF; data_in_1 = 32'h1357_9BDF; start = 1'b1;
    tick(); start = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    end
    done_count = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) done_count++;
      tick();
    end
    checks++;
    if (done_count !== 0) begin errors++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", done_count); end
    run_op(2'd2, 32'd10, 32'd3, lat, rh, rl, rdz, bb);
    checks++;
    if (rl !== 32'd3 || rh !== 32'd1 || lat !== 35) begin
      errors++; $display("FAIL reset_mid_recover: got lo=%h hi=%h lat=%0d expected lo=3 hi=1 lat=35", rl, rh, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h1, l1, eh, el;
    logic edz, rdz;
    int lat, bb, hold_bad;
    run_op(2'd1, 32'hFFFF_8000, 32'h0001_2345, lat, h1, l1, rdz, bb);
    model(2'd1, 32'hFFFF_8000, 32'h0001_2345, eh, el, edz);
    checks++;
    if (h1 !== eh || l1 !== el) begin
      errors++; $display("FAIL b2b_first: got hi=%h lo=%h expected hi=%h lo=%h", h1, l1, eh, el);
    end
    op = 2'd3; data_in_0 = 32'hFFFF_FF00; data_in_1 = 32'd7; start = 1'b1;
    tick(); start = 1'b0;
    lat = 1; hold_bad = 0;
    while (!done && lat < 100) begin
      if (hi !== h1 || lo !== l1) hold_bad++;
      tick();
      lat++;
    end
    model(2'd3, 32'hFFFF_FF00, 32'd7, eh, el, edz);
    checks++;
    if (lat !== 35 || hold_bad !== 0) begin
      errors++; $display("FAIL b2b_timing: got lat=%0d hold_bad=%0d expected lat=35 hold_bad=0", lat, hold_bad);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      errors++; $display("FAIL b2b_second: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, eh, el);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'd0; data_in_0 = '0; data_in_1 = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    test_reset();
    test_directed();
    test_random();
    test_mthi_mtlo();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle integer multiply/divide unit for the 32-bit MIPS datapath.
- Serves MULT, MULTU, DIV and DIVU; owns the HI/LO architectural registers; supports MTHI/MTLO writes.
- Sits beside the 32-bit ALU in EX: single-cycle ALU ops go to the ALU, long ops go here. The control unit stalls on busy.
- Radix-2 iterative engine: shift-add multiply, restoring divide; one bit per cycle.

Parameters:
WIDTH, 32, operand and HI/LO width
ITERATIONS, WIDTH, RUN-state cycle count (always equal to WIDTH)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
data_in_0  input  WIDTH  rs operand (multiplicand / dividend)
data_in_1  input  WIDTH  rt operand (multiplier / divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in progress (PREP, RUN, FIX)
done  output  1  one-cycle pulse; HI/LO hold the new result
div_by_zero  output  1  one-cycle pulse with done when a DIV/DIVU divisor is 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset: state=IDLE; hi=0, lo=0; busy=0, done=0, div_by_zero=0; counter=0.
  - Reset mid-operation aborts the operation; HI/LO are cleared and no done pulse is produced.
- States and transitions:
  - IDLE -> PREP on start.
  - PREP -> DONE when op is DIV/DIVU and divisor=0; otherwise PREP -> RUN.
  - RUN -> FIX after ITERATIONS cycles.
  - FIX -> DONE.
  - DONE -> IDLE unconditionally.
- Timing: start sampled at edge k.
  - PREP cycle k+1; RUN cycles k+2..k+33; FIX cycle k+34; DONE cycle k+35.
  - done=1 and the new hi/lo are visible during cycle k+35.
  - Divide-by-zero case: done and div_by_zero both high during cycle k+2.
- busy is high exactly in PREP, RUN and FIX. It is 0 in IDLE and DONE.
- PREP:
  - Latches the operands and op.
  - Signed ops (MULT, DIV): takes magnitudes and records the sign of each operand.
  - Unsigned ops: uses the operands as-is.
- RUN, multiply: 2*WIDTH-bit product register; each cycle adds the multiplicand if the product LSB is 1, then shifts right 1.
- RUN, divide: {remainder, quotient} register; each cycle shifts left 1 and trial-subtracts the divisor.
  - If non-negative, keeps the difference and sets the quotient LSB to 1.
  - Otherwise restores the remainder and sets the LSB to 0.
- FIX:
  - MULT: negates the 64-bit product if the operand signs differ.
  - DIV: negates the quotient if the operand signs differ; the remainder takes the dividend's sign. Quotient truncates toward zero.
  - Result goes to HI:LO: {hi,lo}=product; lo=quotient, hi=remainder.
- Overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural result of magnitude arithmetic). No flag.
- Divide by zero: lo=0xFFFFFFFF, hi=data_in_0 (dividend as latched), div_by_zero pulse. Applies to both signed and unsigned.
- start while busy or in DONE: ignored.
- hi_we/lo_we:
  - Honoured only in IDLE; writes take effect at the next edge. Dropped while busy or in DONE.
  - hi_we and lo_we together write wdata to both registers.
  - start together with hi_we/lo_we in IDLE: the write is applied and the operation also launches; its result overwrites HI/LO at DONE.
- HI/LO hold their values at all times except on reset, an MTHI/MTLO write, or entry to DONE.

Decomposition:
- Shared package mips_pkg:
  - muldiv_op_t enum: MULTU, MULT, DIVU, DIV.
  - muldiv_state_t enum: IDLE, PREP, RUN, FIX, DONE.
  - Constant DIV_ZERO_QUOTIENT = 32'hFFFFFFFF.
  - WIDTH default constant.
- One sub-module, muldiv_step: purely combinational single-iteration datapath.
  - Inputs: mode, accumulator, operand.
  - Performs the conditional add plus shift-right (multiply) or shift-left plus trial subtract/restore (divide).
  - Instantiated once; the FSM, counter and sign fix-up stay in mult_div_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at edge k -> busy high k+1..k+34; done at k+35 with hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> done and div_by_zero high at k+2; lo=0xFFFFFFFF, hi=100; DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- MTHI 0x1234 in IDLE -> hi=0x1234 next cycle; MTLO 0x55 during RUN -> lo unchanged; start pulsed during RUN -> ignored, single done only.
- Reset asserted at RUN cycle 10 -> next cycle busy=0, done=0, hi=lo=0, state IDLE; a following DIVU 10/3 completes normally with lo=3, hi=1.
- Back-to-back ops: start in the cycle after done -> second op accepted, done 35 cycles later; HI/LO hold the first result until then.
